// File: rtl/stopwatch_pkg.sv
// Shared encodings and BCD limits for the count-up stopwatch.
package stopwatch_pkg;

    // Controller states; the encodings are fixed so they stay stable in debug views.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } sw_state_e;

    // Display selection: centiseconds view or minutes view.
    localparam logic DISP_SS_CC = 1'b0;
    localparam logic DISP_MM_SS = 1'b1;

    // BCD limits: every ones digit tops out at 9, seconds/minutes tens at 5.
    localparam logic [3:0] ONES_MAX     = 4'd9;
    localparam logic [3:0] SEC_TENS_MAX = 4'd5;
    localparam logic [7:0] SEC_MAX_BCD  = {SEC_TENS_MAX, ONES_MAX};  // 59
    localparam logic [7:0] CS_MAX_BCD   = {ONES_MAX, ONES_MAX};      // 99

    // Pack a tens/ones digit pair into one display byte.
    function automatic logic [7:0] bcd_byte(input logic [3:0] tens, input logic [3:0] ones);
        return {tens, ones};
    endfunction

endpackage

// File: rtl/stopwatch_bcd_counter.sv
// Two-digit BCD modulo counter (00 .. TENS_MAX*10+9) with ripple carry.
// carry_out is combinational so a whole cs->sec->min chain advances on one tick.
// hold blocks the register update without masking carry_out, which lets the
// parent detect the terminal count from the carry chain and freeze there.
module bcd_mod_counter
    import stopwatch_pkg::*;
#(
    parameter logic [3:0] TENS_MAX = 4'd9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inc,
    input  logic       clr,
    input  logic       hold,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       carry_out
);

    logic [3:0] tens_q, tens_d;
    logic [3:0] ones_q, ones_d;
    logic       at_max;

    assign at_max    = (tens_q == TENS_MAX) && (ones_q == ONES_MAX);
    assign carry_out = inc && at_max;
    assign tens      = tens_q;
    assign ones      = ones_q;

    // Next digit values: clear wins, then increment with ones->tens carry.
    always_comb begin
        tens_d = tens_q;
        ones_d = ones_q;
        if (clr) begin
            tens_d = 4'd0;
            ones_d = 4'd0;
        end else if (inc && !hold) begin
            if (ones_q == ONES_MAX) begin
                ones_d = 4'd0;
                tens_d = at_max ? 4'd0 : tens_q + 4'd1;
            end else begin
                ones_d = ones_q + 4'd1;
            end
        end
    end

    // Digit registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tens_q <= 4'd0;
            ones_q <= 4'd0;
        end else begin
            tens_q <= tens_d;
            ones_q <= ones_d;
        end
    end

endmodule

// File: rtl/stopwatch.sv
// Count-up stopwatch, 00:00.00 .. 59:59.99, with start/stop, lap freeze and clear.
// Drives a registered 16-bit BCD word for the seven-segment controller.
// DIV = CLK_HZ/TICK_HZ must be an integer of at least 2.
module stopwatch
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_stop,
    input  logic        lap,
    input  logic        clear,
    input  logic        disp_sel,
    output logic [15:0] value,
    output logic        running,
    output logic        lap_active,
    output logic        overflow
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

    sw_state_e   state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic        running_q, running_d;
    logic        lap_active_q, lap_active_d;
    logic        overflow_q, overflow_d;
    logic [7:0]  lap_cs_q, lap_cs_d;
    logic [7:0]  lap_sec_q, lap_sec_d;
    logic [7:0]  lap_min_q, lap_min_d;
    logic [15:0] value_q, value_d;

    logic        tick;
    logic        cnt_clr;
    logic        ovf_hit;
    logic        lap_capture;
    logic        cs_carry, sec_carry, min_carry;
    logic [3:0]  cs_tens, cs_ones, sec_tens, sec_ones, min_tens, min_ones;
    logic [7:0]  live_cs, live_sec, live_min;
    logic [7:0]  src_cs, src_sec, src_min;

    // Centisecond tick: last prescaler count while running.
    assign tick    = (state_q == RUN) && (presc_q == PW'(DIV - 1));
    // Counters are only zeroed by clear from PAUSE.
    assign cnt_clr = (state_q == PAUSE) && clear;
    // A carry out of the minutes counter means the tick arrived at 59:59.99.
    assign ovf_hit = min_carry;

    bcd_mod_counter #(.TENS_MAX(CS_MAX_BCD[7:4])) u_cs (
        .clk       (clk),
        .reset     (reset),
        .inc       (tick),
        .clr       (cnt_clr),
        .hold      (ovf_hit),
        .tens      (cs_tens),
        .ones      (cs_ones),
        .carry_out (cs_carry)
    );

    bcd_mod_counter #(.TENS_MAX(SEC_MAX_BCD[7:4])) u_sec (
        .clk       (clk),
        .reset     (reset),
        .inc       (cs_carry),
        .clr       (cnt_clr),
        .hold      (ovf_hit),
        .tens      (sec_tens),
        .ones      (sec_ones),
        .carry_out (sec_carry)
    );

    bcd_mod_counter #(.TENS_MAX(SEC_MAX_BCD[7:4])) u_min (
        .clk       (clk),
        .reset     (reset),
        .inc       (sec_carry),
        .clr       (cnt_clr),
        .hold      (ovf_hit),
        .tens      (min_tens),
        .ones      (min_ones),
        .carry_out (min_carry)
    );

    assign live_cs  = bcd_byte(cs_tens, cs_ones);
    assign live_sec = bcd_byte(sec_tens, sec_ones);
    assign live_min = bcd_byte(min_tens, min_ones);

    // Controller next state; priority clear > start_stop > lap, lower pulses dropped.
    always_comb begin
        state_d      = state_q;
        lap_active_d = lap_active_q;
        overflow_d   = overflow_q;
        lap_capture  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!clear && start_stop) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (start_stop) begin
                    state_d = PAUSE;
                end else if (lap) begin
                    if (lap_active_q) begin
                        lap_active_d = 1'b0;
                    end else begin
                        lap_active_d = 1'b1;
                        lap_capture  = 1'b1;
                    end
                end
                if (ovf_hit) begin
                    state_d    = PAUSE;
                    overflow_d = 1'b1;
                end
            end
            PAUSE: begin
                if (clear) begin
                    state_d      = IDLE;
                    lap_active_d = 1'b0;
                    overflow_d   = 1'b0;
                end else if (start_stop) begin
                    state_d = RUN;
                end else if (lap && lap_active_q) begin
                    lap_active_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Prescaler: counts only in RUN, holds in PAUSE, zero in/entering IDLE.
    always_comb begin
        presc_d = presc_q;
        if (state_q == RUN) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
        end else if (state_d == IDLE) begin
            presc_d = '0;
        end
    end

    // Lap snapshot of the live count, zeroed together with the counters.
    always_comb begin
        lap_cs_d  = lap_cs_q;
        lap_sec_d = lap_sec_q;
        lap_min_d = lap_min_q;
        if (cnt_clr) begin
            lap_cs_d  = 8'h00;
            lap_sec_d = 8'h00;
            lap_min_d = 8'h00;
        end else if (lap_capture) begin
            lap_cs_d  = live_cs;
            lap_sec_d = live_sec;
            lap_min_d = live_min;
        end
    end

    // Display source and field selection feeding the output register.
    always_comb begin
        src_cs  = lap_active_q ? lap_cs_q  : live_cs;
        src_sec = lap_active_q ? lap_sec_q : live_sec;
        src_min = lap_active_q ? lap_min_q : live_min;
        value_d = {src_sec, src_cs};
        case (disp_sel)
            DISP_SS_CC: value_d = {src_sec, src_cs};
            DISP_MM_SS: value_d = {src_min, src_sec};
            default:    value_d = {src_sec, src_cs};
        endcase
        running_d = (state_d == RUN);
    end

    // State, flag, snapshot and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            presc_q      <= '0;
            running_q    <= 1'b0;
            lap_active_q <= 1'b0;
            overflow_q   <= 1'b0;
            lap_cs_q     <= 8'h00;
            lap_sec_q    <= 8'h00;
            lap_min_q    <= 8'h00;
            value_q      <= 16'h0000;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            running_q    <= running_d;
            lap_active_q <= lap_active_d;
            overflow_q   <= overflow_d;
            lap_cs_q     <= lap_cs_d;
            lap_sec_q    <= lap_sec_d;
            lap_min_q    <= lap_min_d;
            value_q      <= value_d;
        end
    end

    assign value      = value_q;
    assign running    = running_q;
    assign lap_active = lap_active_q;
    assign overflow   = overflow_q;

endmodule

// File: doc/stopwatch.md
Name: stopwatch

Overview:
Count-up stopwatch. It is the counterpart to the countdown timer: it accumulates elapsed time from 00:00.00 up to 59:59.99 instead of decrementing a preset value. The block takes one-cycle pulses from the existing button edge detectors and drives the 16-bit BCD value consumed by fnd_controller. It also supports start/stop, lap freeze and clear.

Parameters:
CLK_HZ, 100_000_000, system clock frequency in Hz
TICK_HZ, 100, centisecond tick rate; prescaler divisor DIV = CLK_HZ/TICK_HZ (must be an integer ≥ 2)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (reset = 0 resets the block)
start_stop  in  1  one-cycle pulse, start/stop request
lap  in  1  one-cycle pulse, lap freeze/release
clear  in  1  one-cycle pulse, zero the stopwatch
disp_sel  in  1  0 = show SS.cc, 1 = show MM:SS
value  out  16  BCD display word {tens[3:0], ones[3:0], tens[3:0], ones[3:0]}
running  out  1  1 while in state RUN
lap_active  out  1  1 while the display is frozen
overflow  out  1  sticky flag, set when the count hits 59:59.99

Behaviour:
- Reset (reset = 0, asynchronous): state = IDLE; prescaler, all counters, lap registers, value, running, lap_active and overflow = 0.
- Counters (BCD):
  - cs: 00–99
  - sec: 00–59
  - min: 00–59
  - Ones digits wrap 9→0 and carry into the tens digit.
  - Carries ripple within the same tick.
- Prescaler:
  - Counts 0..DIV-1, only in RUN.
  - tick is asserted when prescaler == DIV-1; the prescaler returns to 0 on the same edge.
  - In PAUSE the prescaler holds, so resume keeps the fractional interval.
  - Entering IDLE zeroes the prescaler.
- FSM states: IDLE, RUN, PAUSE.
  - IDLE: start_stop → RUN. lap is ignored. clear keeps IDLE.
  - RUN: start_stop → PAUSE. lap toggles the freeze (detailed below). clear is ignored.
  - PAUSE: start_stop → RUN. clear → IDLE, zeroes all counters and clears lap_active and overflow. lap while lap_active releases the freeze; lap while not lap_active is ignored.
- Same-cycle priority: clear > start_stop > lap. A lower-priority pulse arriving in the same cycle as a higher one that acts is dropped.
- Lap freeze:
  - In RUN, lap with lap_active = 0 copies the current cs/sec/min into the lap registers and sets lap_active = 1.
  - In RUN, lap with lap_active = 1 clears lap_active.
  - Counting continues underneath while frozen.
- Overflow: a tick at 59:59.99 does not increment. Counters hold, state → PAUSE, overflow = 1. overflow stays 1 until clear in PAUSE.
- Display source: lap registers if lap_active, else live counters.
  - disp_sel = 0: value = {sec, cs}.
  - disp_sel = 1: value = {min, sec}.
- value is registered, with one cycle of latency after a counter, lap or disp_sel change. running and lap_active are registered state outputs.
- Reset asserted mid-count: every register returns to its reset value immediately (asynchronous). Counting restarts only after reset is released and then a start_stop pulse arrives.

Decomposition:
- Package stopwatch_pkg holds:
  - state encodings IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2
  - DISP_SS_CC = 1'b0, DISP_MM_SS = 1'b1
  - BCD limit constants 9/5/59/99
- Sub-module bcd_mod_counter (parameter TENS_MAX):
  - inputs clk, reset, inc
  - outputs tens, ones, carry_out; carry_out is combinational and high when inc && value == max
  - 10*TENS_MAX+9 max ⇒ instantiated for cs (TENS_MAX = 9), sec (5) and min (5).
- The top level holds the prescaler, FSM, lap registers, overflow logic and output mux.

Test Plan:
- Bench setting CLK_HZ = 10, TICK_HZ = 1 (DIV = 10) for all cases below.
- Reset, then start_stop, then wait 250 clk → value = 16'h0025 (disp_sel = 0), running = 1.
- RUN to 00:00.37, start_stop, wait 100 clk, start_stop, wait 30 clk → value = 16'h0040. This checks that the prescaler holds during PAUSE.
- RUN to 00:12.34, lap, wait 500 clk → value stays 16'h1234 while lap_active = 1. Then lap → value shows the live count, 16'h1284, one cycle later.
- Preload via run to 59:59.99, next tick → value holds 16'h5999 (disp_sel = 0) and 16'h5959 (disp_sel = 1); overflow = 1; state = PAUSE. Then clear → value = 16'h0000, overflow = 0.
- In RUN, pulse clear and start_stop in the same cycle → clear is ignored in RUN, so the block enters PAUSE with the count kept. In PAUSE, pulse clear and start_stop in the same cycle → IDLE with value 16'h0000.
- Drive reset = 0 mid-count at 00:07.xx → outputs are 0 within the same cycle. After release, with no start_stop for 200 clk, value stays 0.
